// File: rtl/flt2fix_pkg.sv
// rtl/flt2fix_pkg.sv - shared types and constants for the float16 to fixed 8.8 engine
package flt2fix_pkg;

   typedef enum logic [3:0] {
      IDLE, RD_LO, RD_HI, CAPT, DECODE, SHIFT, NEG, WR_LO, WR_HI, DONE
   } state_t;

   localparam int EXP_BIAS = 15;
   localparam int FIX_FRAC = 8;
   localparam int MANT_W   = 10;
   localparam int EXP_W    = 5;

   localparam logic [15:0] SAT_POS = 16'h7FFF;
   localparam logic [15:0] SAT_NEG = 16'h8000;

   localparam logic [EXP_W-1:0] ZERO_EXP = 5'd0;
   localparam logic [EXP_W-1:0] INF_EXP  = 5'd31;

   // {1,m} scaled by 2^(e-SHIFT_PIVOT) is the 8.8 value; past SAT_EXP the integer part overflows
   localparam logic [EXP_W-1:0] SHIFT_PIVOT = EXP_W'(EXP_BIAS - FIX_FRAC + MANT_W);
   localparam logic [EXP_W-1:0] SAT_EXP     = SHIFT_PIVOT + EXP_W'(16 - (MANT_W + 1));
   localparam logic [3:0]       MAX_RSHIFT  = 4'(MANT_W + 1);

endpackage

// File: rtl/flt2fix_engine_classify.sv
// rtl/flt2fix_engine_classify.sv - combinational float16 unpack: zero/saturate flags, shift direction and count
module flt16_classify
   import flt2fix_pkg::*;
(
   input  logic [15:0] flt_i,
   output logic        is_zero_o,
   output logic        is_sat_o,
   output logic        exact_neg_min_o,
   output logic        dir_left_o,
   output logic [3:0]  k_o
);

   logic                s;
   logic [EXP_W-1:0]    e;
   logic [MANT_W-1:0]   m;
   logic [EXP_W-1:0]    rdiff;

   assign s = flt_i[15];
   assign e = flt_i[14:10];
   assign m = flt_i[9:0];

   assign is_zero_o       = (e == ZERO_EXP);
   // -128.0 is the one value at SAT_EXP that still fits 8.8 exactly
   assign exact_neg_min_o = s && (e == SAT_EXP) && (m == '0);
   assign is_sat_o        = (e == INF_EXP) || ((e >= SAT_EXP) && !exact_neg_min_o);
   assign dir_left_o      = (e >= SHIFT_PIVOT);
   assign rdiff           = SHIFT_PIVOT - e;

   always_comb begin
      k_o = 4'd0;
      if (is_zero_o || is_sat_o || exact_neg_min_o) begin
         k_o = 4'd0;
      end else if (dir_left_o) begin
         k_o = 4'(e - SHIFT_PIVOT);
      end else if (rdiff > {1'b0, MAX_RSHIFT}) begin
         k_o = MAX_RSHIFT;
      end else begin
         k_o = rdiff[3:0];
      end
   end

endmodule

// File: rtl/flt2fix_engine.sv
// rtl/flt2fix_engine.sv - sequential float16 to fixed 8.8 converter reading and writing byte memory
module flt2fix_engine
   import flt2fix_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int SRC_ADDR = 2,
   parameter int DST_ADDR = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        mem_wdata,
   output logic              mem_we
);

   state_t             state_q;
   logic [7:0]         lo_q, hi_q;
   logic [15:0]        mag_q, res_q, res_d;
   logic [3:0]         k_q;
   logic               dir_left_q, sat_q, done_q, we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [7:0]         wdata_q;

   logic               is_zero, is_sat, exact_neg_min, dir_left;
   logic [3:0]         k;

   flt16_classify u_classify (
      .flt_i           ({hi_q, lo_q}),
      .is_zero_o       (is_zero),
      .is_sat_o        (is_sat),
      .exact_neg_min_o (exact_neg_min),
      .dir_left_o      (dir_left),
      .k_o             (k)
   );

   // saturated magnitudes already carry their final two's-complement pattern
   assign res_d = (hi_q[7] && !sat_q) ? (~mag_q + 16'd1) : mag_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         lo_q       <= '0;
         hi_q       <= '0;
         mag_q      <= '0;
         res_q      <= '0;
         k_q        <= '0;
         dir_left_q <= 1'b0;
         sat_q      <= 1'b0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q  <= ADDR_W'(SRC_ADDR);
                  state_q <= RD_LO;
               end
            end
            RD_LO: begin
               addr_q  <= ADDR_W'(SRC_ADDR + 1);
               state_q <= RD_HI;
            end
            RD_HI: begin
               lo_q    <= mem_rdata;
               state_q <= CAPT;
            end
            CAPT: begin
               hi_q    <= mem_rdata;
               state_q <= DECODE;
            end
            DECODE: begin
               sat_q      <= is_sat || exact_neg_min;
               dir_left_q <= dir_left;
               k_q        <= k;
               if (is_zero)
                  mag_q <= 16'h0000;
               else if (is_sat)
                  mag_q <= hi_q[7] ? SAT_NEG : SAT_POS;
               else if (exact_neg_min)
                  mag_q <= SAT_NEG;
               else
                  mag_q <= {5'd0, 1'b1, hi_q[1:0], lo_q};
               state_q <= (k == 4'd0) ? NEG : SHIFT;
            end
            SHIFT: begin
               mag_q <= dir_left_q ? (mag_q << 1) : (mag_q >> 1);
               k_q   <= k_q - 4'd1;
               if (k_q == 4'd1)
                  state_q <= NEG;
            end
            NEG: begin
               res_q   <= res_d;
               addr_q  <= ADDR_W'(DST_ADDR);
               wdata_q <= res_d[7:0];
               we_q    <= 1'b1;
               state_q <= WR_LO;
            end
            WR_LO: begin
               addr_q  <= ADDR_W'(DST_ADDR + 1);
               wdata_q <= res_q[15:8];
               we_q    <= 1'b1;
               state_q <= WR_HI;
            end
            WR_HI: begin
               we_q    <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               if (!start) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               we_q    <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign done      = done_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_flt2fix_engine.sv
// tb/tb_flt2fix_engine.sv - scoreboard bench for flt2fix_engine with directed float16 vectors
module tb_flt2fix_engine;

   localparam int SRC = 2;
   localparam int DST = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       done, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] mem [256];

   logic       pl_en = 1'b0;
   logic [7:0] pl_addr = 8'h00;
   logic [7:0] pl_data = 8'h00;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pops = 0;
   int we_total = 0;
   logic done_prev = 1'b0;

   typedef struct {
      logic [15:0] res;
      int          cyc;
      int          we_base;
      logic [15:0] src;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   flt2fix_engine #(.ADDR_W(8), .SRC_ADDR(SRC), .DST_ADDR(DST)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
      else if (pl_en)
         mem[pl_addr] <= pl_data;
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset && done && !done_prev) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("dst_for_%h", e.src), {16'h0, mem[DST+1], mem[DST]}, {16'h0, e.res});
            check($sformatf("done_cycle_for_%h", e.src), cyc, e.cyc);
            check($sformatf("we_pulses_for_%h", e.src), we_total - e.we_base, 32'd2);
            pops++;
         end
      end
      if (mem_we)
         we_total++;
      done_prev = done;
   end

   task automatic poke(input int a, input logic [7:0] d);
      pl_en   = 1'b1;
      pl_addr = 8'(a);
      pl_data = d;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic preload(input logic [15:0] f, input logic [15:0] dst);
      @(negedge clk);
      poke(SRC, f[7:0]);
      poke(SRC + 1, f[15:8]);
      poke(DST, dst[7:0]);
      poke(DST + 1, dst[15:8]);
   endtask

   task automatic run(input logic [15:0] f, input logic [15:0] res, input int k, input int hold);
      int p0, base;
      bit ok;
      preload(f, 16'h55AA);
      p0   = pops;
      base = we_total;
      start = 1'b1;
      sb_q.push_back('{res, cyc + 8 + k, base, f});
      repeat (hold) @(negedge clk);
      if (hold >= 9 + k)
         check("held_start_done_high", {31'd0, done}, 32'd1);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (pops != p0) ok = 1'b1;
         else @(negedge clk);
      end
      check($sformatf("done_seen_for_%h", f), {31'd0, ok}, 32'd1);
      if (!ok) sb_q.delete();
      repeat (2) @(negedge clk);
      check("done_low_after_start_drop", {31'd0, done}, 32'd0);
      check("we_pulses_total", we_total - base, 32'd2);
   endtask

   task automatic abort(input logic [15:0] f, input int at, input logic pre_we);
      int c0;
      preload(f, 16'h1234);
      c0 = cyc + 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + at) @(negedge clk);
      check("we_before_reset", {31'd0, mem_we}, {31'd0, pre_we});
      reset = 1'b0;
      #1;
      check("reset_async_done", {31'd0, done}, 32'd0);
      check("reset_async_we", {31'd0, mem_we}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_dst_unchanged", {16'h0, mem[DST+1], mem[DST]}, 32'h0000_1234);
      check("abort_no_done", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_we", {31'd0, mem_we}, 32'd0);
      check("reset_addr", {24'd0, mem_addr}, 32'd0);
      check("reset_wdata", {24'd0, mem_wdata}, 32'd0);
      reset = 1'b1;

      run(16'h3C00, 16'h0100, 2, 1);
      run(16'hC200, 16'hFD00, 1, 1);
      run(16'h1C00, 16'h0001, 10, 1);
      run(16'h57FF, 16'h7FF0, 4, 1);
      run(16'h5800, 16'h7FFF, 0, 1);
      run(16'hD800, 16'h8000, 0, 1);
      run(16'h7C00, 16'h7FFF, 0, 1);
      run(16'h0000, 16'h0000, 0, 1);
      run(16'h8000, 16'h0000, 0, 1);
      run(16'h0001, 16'h0000, 0, 1);
      run(16'h0BFF, 16'h0000, 11, 1);

      run(16'h3C00, 16'h0100, 2, 12);
      run(16'hC200, 16'hFD00, 1, 1);

      abort(16'h3C00, 4, 1'b0);
      abort(16'h3C00, 7, 1'b1);
      run(16'h3C00, 16'h0100, 2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flt2fix_engine.md
Name: flt2fix_engine

Overview:
- Hardware float16 (1.5.10, bias 15) to fixed 8.8 two's-complement converter.
- Sits directly downstream of the fixed-to-float program. It reads the float16 result bytes from data memory and writes the fixed 8.8 word back, closing the round-trip check.
- Sequential engine: byte-wide memory reads, iterative 1-bit/cycle shifter, saturation, byte writes, and a start/done handshake identical in style to top_level.

Parameters:
- ADDR_W, 8, data-memory address width.
- SRC_ADDR, 2, address of float low byte; the high byte is at SRC_ADDR+1.
- DST_ADDR, 4, address of fixed low byte; the high byte is at DST_ADDR+1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  in  1  request; may be held high for several cycles.
- done  out  1  result written; level signal.
- mem_addr  out  ADDR_W  data-memory byte address.
- mem_rdata  in  8  read data; synchronous read, 1-cycle latency.
- mem_wdata  out  8  write data.
- mem_we  out  1  write enable; the write commits on the rising clk edge.

Behaviour:
- Reset values: state IDLE, done=0, mem_we=0, mem_addr=0, mem_wdata=0, all datapath registers 0.
- States: IDLE, RD_LO, RD_HI, CAPT, DECODE, SHIFT, NEG, WR_LO, WR_HI, DONE.
- IDLE: on the edge where start=1, go to RD_LO. This is edge 0.
- RD_LO: drive mem_addr=SRC_ADDR.
- RD_HI: drive mem_addr=SRC_ADDR+1; capture the low byte.
- CAPT: capture the high byte.
- DECODE: split s, e[4:0], m[9:0]; form mag = {1,m} in 16 bits; compute direction and k.
- Decode cases:
  - e=0 (zero/denormal): result 0, k=0.
  - e=31: saturate.
  - e>=22: saturate, except s=1, e=22, m=0, which gives 0x8000 exactly.
  - 17<=e<=21: shift left, k=e-17.
  - e<17: shift right, k=min(17-e, 11). Truncation toward zero on magnitude.
- Saturation values: 0x7FFF when s=0, 0x8000 when s=1. k=0 and NEG is bypassed.
- SHIFT: shift mag 1 bit per cycle for k cycles. When k=0, DECODE goes straight to NEG.
- NEG: if s=1 and not saturated, result = ~mag + 1; otherwise result = mag. A zero magnitude stays 0x0000 (no -0).
- WR_LO: mem_addr=DST_ADDR, mem_wdata=result[7:0], mem_we=1.
- WR_HI: mem_addr=DST_ADDR+1, mem_wdata=result[15:8], mem_we=1.
- DONE: done=1, mem_we=0. The engine stays in DONE while start=1 and returns to IDLE when start=0; done falls on that transition.
- Latency: done first high after edge 7+k. Low-byte write at edge 6+k, high-byte write at edge 7+k.
- start while not in IDLE is ignored, including a held start.
- mem_we is asserted only in WR_LO/WR_HI and never for more than 2 cycles per conversion.
- Reset mid-operation: done=0 and mem_we=0 asynchronously. Bytes not yet written stay unchanged, and no partial write occurs on the reset edge.

Decomposition:
- Package flt2fix_pkg:
  - state_t enum.
  - EXP_BIAS=15, FIX_FRAC=8, MANT_W=10, EXP_W=5.
  - SAT_POS=16'h7FFF, SAT_NEG=16'h8000.
  - ZERO_EXP=0, INF_EXP=31.
  - SHIFT_PIVOT=17 (EXP_BIAS-FIX_FRAC+MANT_W... fixed by design).
- Sub-module flt16_classify: combinational unpack of s/e/m. It produces is_zero, is_sat, exact_neg_min, dir_left, and k[3:0].

Test Plan:
- Input 0x3C00 -> DST 0x0100; k=2; done first high after edge 9.
- Input 0xC200 (-3.0) -> 0xFD00. Input 0x1C00 (2^-8) -> 0x0001 with k=10, done after edge 17.
- Input 0x57FF -> 0x7FF0. Input 0x5800 -> 0x7FFF. Input 0xD800 -> 0x8000. Input 0x7C00 -> 0x7FFF. All saturating cases take k=0 and done after edge 7.
- Inputs 0x0000, 0x8000, 0x0001 -> 0x0000 each. Input 0x0BFF (e=2) -> 0x0000 via 11 right shifts.
- Hold start high for 12 cycles -> exactly one conversion with exactly 2 mem_we pulses. Done stays high until start drops, then IDLE; a second start pulse reconverts correctly.
- Pull reset low during SHIFT for input 0x3C00 -> done=0 and mem_we=0 immediately, DST bytes keep their prior value. After reset release and start, DST=0x0100.
